clint: RTL and testbench
========================

CLINT -- requirements
Module: clint

Interface
REQ-001 Parameter RTC_DIV, default 1: number of clk cycles per mtime increment, legal range 1..65535.
REQ-002 Parameter BASE_ADDR, default 32'h0200_0000: device base address, 64 KiB aligned.
REQ-003 Port rst  input  1: synchronous, active-low reset.
REQ-004 Port clk  input  1: clock; all state updates on its rising edge.
REQ-005 Port mem_valid  input  1: request valid, held by the master until mem_ready.
REQ-006 Port mem_addr  input  32: byte address; only bits [15:2] are decoded.
REQ-007 Port mem_wdata  input  32: write data.
REQ-008 Port mem_wstrb  input  4: byte write enables; all-zero means read.
REQ-009 Port mem_rdata  output  32: read data, valid while mem_ready=1, otherwise 0.
REQ-010 Port mem_ready  output  1: one-cycle completion pulse.
REQ-011 Port timer_irpt  output  1: machine timer interrupt level, to the CSR unit.
REQ-012 Port soft_irpt  output  1: machine software interrupt level, to the CSR unit.

Function
REQ-013 Register map, offset = addr[15:0]: 0x0000 msip (bit 0 only, bits 31:1 read 0); 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32]; 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
REQ-014 Other offsets: read 0, writes ignored, mem_ready still returned.
REQ-015 Handshake FSM has two states, IDLE and RESP, and resets to IDLE.
REQ-016 IDLE with mem_valid=1: the request is accepted, any write is performed at that edge, read data is latched, and the FSM moves to RESP.
REQ-017 RESP: mem_ready=1 for exactly one cycle, then the FSM returns to IDLE; mem_valid is not sampled in RESP. Fixed latency: 1 cycle from acceptance to ready.
REQ-018 Back-to-back requests complete at most once every 2 cycles.
REQ-019 Writes: byte lane n updates only when mem_wstrb[n]=1.
REQ-020 Reads return register values as they were before any same-edge update.
REQ-021 Prescaler: counter 0..RTC_DIV-1 increments each cycle; on reaching RTC_DIV-1 it wraps to 0 and asserts a one-cycle tick.
REQ-022 On tick: mtime <= mtime+1, 64-bit, carrying into the upper word; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
REQ-023 A bus write to either mtime word in the same cycle as a tick suppresses that increment entirely; the write value wins and the prescaler continues unaffected.
REQ-024 timer_irpt is registered as (mtime >= mtimecmp), unsigned 64-bit, so it lags a register change by 1 cycle.
REQ-025 soft_irpt is registered from msip[0], so it asserts 1 cycle after the write edge.
REQ-026 Both interrupt outputs are levels; only software clears them, by writing mtimecmp or msip.
REQ-027 A partial update of mtimecmp (one word only) takes effect on the comparison immediately.

Reset
REQ-028 On rst=0 at a clk edge: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0, FSM=IDLE.
REQ-029 On rst=0 at a clk edge: mem_ready=0, mem_rdata=0, timer_irpt=0, soft_irpt=0.
REQ-030 Reset asserted while in RESP aborts the transaction; no mem_ready pulse follows reset release.
REQ-031 Reset asserted in the same cycle as a write: the reset wins.

Verification
REQ-032 RTC_DIV=4, release reset, idle 40 cycles -> mtime=10, timer_irpt=0, soft_irpt=0.
REQ-033 Write 0x4000=20, then 0x4004=0 -> timer_irpt rises exactly 1 cycle after mtime reaches 20; write 0x4004=1 -> timer_irpt falls the next cycle.
REQ-034 Write 0x0000=0xFFFF_FFFF -> soft_irpt=1 one cycle later; read 0x0000 returns 0x0000_0001; write 0 -> soft_irpt=0.
REQ-035 Write mtime lo=0xFFFF_FFFF and hi=0xFFFF_FFFF, then wait one tick -> mtime=0; a write landing on a tick edge -> the written value is held with no increment.
REQ-036 mem_wstrb=4'b0010, wdata=0x0000_AB00 to 0x4000 with mtimecmp lo=0xFFFF_FFFF -> mtimecmp lo=0xFFFF_ABFF; read of 0x1234 -> 0 with mem_ready after 1 cycle.
REQ-037 Hold mem_valid continuously -> mem_ready pulses every 2nd cycle; assert rst during RESP -> no mem_ready pulse and all outputs 0.

Source files
------------

// File: rtl/clint.sv
// Core-local interruptor: machine timer (mtime/mtimecmp) and software interrupt (msip)
// behind a simple valid/ready memory port.
//
// Parameters
//   RTC_DIV    clk cycles per mtime increment (1..65535)
//   BASE_ADDR  device base address, 64 KiB aligned; the interconnect selects the device,
//              so only the in-window offset is decoded here
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous, active-low reset
//   mem_valid   request valid, held by the master until mem_ready
//   mem_addr    byte address, bits [15:2] decoded
//   mem_wdata   write data
//   mem_wstrb   byte write enables, all-zero means read
//   mem_rdata   read data while mem_ready=1, otherwise 0
//   mem_ready   one-cycle completion pulse
//   timer_irpt  machine timer interrupt level
//   soft_irpt   machine software interrupt level
module clint #(
  parameter int unsigned RTC_DIV   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        timer_irpt,
  output logic        soft_irpt
);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  localparam logic [15:0] PrescMax = 16'(RTC_DIV - 1);

  // Word offsets (byte offset >> 2) of the implemented registers.
  localparam logic [13:0] WordMsip     = 14'h0000;
  localparam logic [13:0] WordCmpLo    = 14'h1000;
  localparam logic [13:0] WordCmpHi    = 14'h1001;
  localparam logic [13:0] WordMtimeLo  = 14'h2FFE;
  localparam logic [13:0] WordMtimeHi  = 14'h2FFF;

  state_e      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [31:0] rdata_q, rdata_d;
  logic        timer_irpt_q, soft_irpt_q;

  logic [13:0] word;
  logic        accept;
  logic        wr;
  logic        tick;

  // Device selection happens upstream; the remaining address bits and the base are
  // deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{mem_addr[31:16], mem_addr[1:0], BASE_ADDR};

  assign word   = mem_addr[15:2];
  assign accept = (state_q == StIdle) && mem_valid;
  assign wr     = accept && (mem_wstrb != 4'b0000);
  assign tick   = (presc_q == PrescMax);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Handshake FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (mem_valid) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Read mux; captures pre-update register values at the acceptance edge.
  always_comb begin
    rdata_d = rdata_q;
    if (accept) begin
      case (word)
        WordMsip:    rdata_d = {31'b0, msip_q};
        WordCmpLo:   rdata_d = mtimecmp_q[31:0];
        WordCmpHi:   rdata_d = mtimecmp_q[63:32];
        WordMtimeLo: rdata_d = mtime_q[31:0];
        WordMtimeHi: rdata_d = mtime_q[63:32];
        default:     rdata_d = 32'b0;
      endcase
    end
  end

  // Prescaler, timer and register writes.
  always_comb begin
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr) begin
      case (word)
        WordMsip:    if (mem_wstrb[0]) msip_d = mem_wdata[0];
        WordCmpLo:   mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], mem_wdata, mem_wstrb);
        WordCmpHi:   mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], mem_wdata, mem_wstrb);
        // A write to either mtime word overrides that cycle's increment entirely.
        WordMtimeLo: mtime_d = {mtime_q[63:32],
                                merge_bytes(mtime_q[31:0], mem_wdata, mem_wstrb)};
        WordMtimeHi: mtime_d = {merge_bytes(mtime_q[63:32], mem_wdata, mem_wstrb),
                                mtime_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      presc_q      <= 16'd0;
      mtime_q      <= 64'd0;
      mtimecmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q       <= 1'b0;
      rdata_q      <= 32'd0;
      timer_irpt_q <= 1'b0;
      soft_irpt_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      msip_q       <= msip_d;
      rdata_q      <= rdata_d;
      timer_irpt_q <= (mtime_q >= mtimecmp_q);
      soft_irpt_q  <= msip_q;
    end
  end

  always_comb begin
    mem_ready  = (state_q == StResp);
    mem_rdata  = mem_ready ? rdata_q : 32'd0;
    timer_irpt = timer_irpt_q;
    soft_irpt  = soft_irpt_q;
  end

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint with RTC_DIV=4. Read expectations go into a scoreboard
// queue when a request is driven and are popped when mem_ready is seen. mtime is
// predicted in closed form from the number of clock edges since reset (one increment
// per 4 edges) relative to the last bus write of mtime.
module tb_clint;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        timer_irpt;
  logic        soft_irpt;

  clint #(.RTC_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .timer_irpt (timer_irpt),
    .soft_irpt  (soft_irpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned edges    = 0;  // rising edges since reset release
  logic [63:0] base_val = 64'd0;
  int unsigned base_edges = 0;
  logic [31:0] sb[$];
  logic        t_at_ready, s_at_ready;

  always @(posedge clk) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  function automatic logic [63:0] model_mtime(input int unsigned n);
    return base_val + 64'(n / 4) - 64'(base_edges / 4);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One bus transaction, started at a negedge with the FSM idle.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input logic chk_rd,
                      input logic [31:0] exp_rd, input string tag);
    int unsigned k;
    int          lat;
    logic        got;
    logic [63:0] cur;
    logic [31:0] exp_pop;
    k = edges;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    if (chk_rd) sb.push_back(exp_rd);
    if (wstrb != 4'b0000 && addr[15:0] == 16'hBFF8) begin
      cur = model_mtime(k);
      base_val = {cur[63:32], wdata};
      base_edges = k + 1;
    end else if (wstrb != 4'b0000 && addr[15:0] == 16'hBFFC) begin
      cur = model_mtime(k);
      base_val = {wdata, cur[31:0]};
      base_edges = k + 1;
    end
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (mem_ready) got = 1'b1;
    end
    chk({tag, "_ready"}, 64'(got), 64'd1);
    if (got) begin
      chk({tag, "_latency"}, 64'(lat), 64'd1);
      t_at_ready = timer_irpt;
      s_at_ready = soft_irpt;
    end
    if (chk_rd) begin
      exp_pop = sb.pop_front();
      if (got) chk({tag, "_rdata"}, 64'(mem_rdata), 64'(exp_pop));
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
    @(negedge clk);
  endtask

  task automatic rd_mtime(input logic hi, input string tag);
    logic [63:0] m;
    m = model_mtime(edges);
    if (hi) xfer(32'h0200_BFFC, 32'd0, 4'b0000, 1'b1, m[63:32], tag);
    else    xfer(32'h0200_BFF8, 32'd0, 4'b0000, 1'b1, m[31:0], tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pat;
    logic        seen;
    logic [31:0] e;

    rst = 1'b0; mem_valid = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(mem_ready), 64'd0);
    chk("reset_rdata", 64'(mem_rdata), 64'd0);
    chk("reset_timer", 64'(timer_irpt), 64'd0);
    chk("reset_soft", 64'(soft_irpt), 64'd0);
    rst = 1'b1;

    // Idle 40 cycles: mtime = 10.
    for (int i = 0; i < 100 && edges < 40; i++) @(negedge clk);
    chk("idle40_timer", 64'(timer_irpt), 64'd0);
    chk("idle40_soft", 64'(soft_irpt), 64'd0);
    rd_mtime(1'b0, "idle40_mtime_lo");
    rd_mtime(1'b1, "idle40_mtime_hi");

    // Timer compare at 20; lower-word-only write leaves the upper word all ones.
    xfer(32'h0200_4000, 32'd20, 4'hF, 1'b0, 32'd0, "wr_cmp_lo");
    chk("cmp_lo_only_timer", 64'(timer_irpt), 64'd0);
    xfer(32'h0200_4004, 32'd0, 4'hF, 1'b0, 32'd0, "wr_cmp_hi");
    for (int i = 0; i < 400 && model_mtime(edges) < 64'd20; i++) @(negedge clk);
    chk("timer_at_mtime20", 64'(timer_irpt), 64'd0);
    @(negedge clk);
    chk("timer_rise", 64'(timer_irpt), 64'd1);
    xfer(32'h0200_4004, 32'd1, 4'hF, 1'b0, 32'd0, "wr_cmp_hi1");
    chk("timer_hold_at_ready", 64'(t_at_ready), 64'd1);
    chk("timer_fall", 64'(timer_irpt), 64'd0);

    // Software interrupt.
    xfer(32'h0200_0000, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'd0, "wr_msip1");
    chk("soft_at_ready", 64'(s_at_ready), 64'd0);
    chk("soft_rise", 64'(soft_irpt), 64'd1);
    xfer(32'h0200_0000, 32'd0, 4'h0, 1'b1, 32'h0000_0001, "rd_msip");
    xfer(32'h0200_0000, 32'd0, 4'hF, 1'b0, 32'd0, "wr_msip0");
    chk("soft_fall", 64'(soft_irpt), 64'd0);

    // mtime 64-bit wrap.
    xfer(32'h0200_BFFC, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'd0, "wr_mtime_hi");
    xfer(32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'd0, "wr_mtime_lo");
    repeat (4) @(negedge clk);
    rd_mtime(1'b0, "wrap_mtime_lo");
    rd_mtime(1'b1, "wrap_mtime_hi");

    // Write landing on a tick edge: written value held, no increment.
    for (int i = 0; i < 4 && (edges % 4) != 3; i++) @(negedge clk);
    xfer(32'h0200_BFF8, 32'h1234_5678, 4'hF, 1'b0, 32'd0, "wr_mtime_tick");
    xfer(32'h0200_BFF8, 32'd0, 4'h0, 1'b1, 32'h1234_5678, "tick_write_held");
    repeat (8) @(negedge clk);
    rd_mtime(1'b0, "presc_continues");

    // Byte-lane write and unmapped read.
    xfer(32'h0200_4000, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'd0, "wr_cmp_lo_ones");
    xfer(32'h0200_4000, 32'h0000_AB00, 4'b0010, 1'b0, 32'd0, "wr_cmp_byte1");
    xfer(32'h0200_4000, 32'd0, 4'h0, 1'b1, 32'hFFFF_ABFF, "rd_cmp_lo");
    xfer(32'h0200_4004, 32'd0, 4'h0, 1'b1, 32'h0000_0001, "rd_cmp_hi");
    xfer(32'h0200_1234, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'd0, "wr_unmapped");
    xfer(32'h0200_1234, 32'd0, 4'h0, 1'b1, 32'd0, "rd_unmapped");

    // Valid held continuously: ready every 2nd cycle.
    mem_valid = 1'b1; mem_addr = 32'h0200_0000; mem_wstrb = 4'h0;
    for (int i = 0; i < 4; i++) sb.push_back(32'd0);
    pat = 8'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat[i] = mem_ready;
      if (mem_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("held_rdata", 64'(mem_rdata), 64'(e));
      end
    end
    mem_valid = 1'b0;
    sb.delete();
    chk("held_pattern", 64'(pat), 64'h55);
    @(negedge clk);

    // Raise both interrupts, then reset during RESP.
    xfer(32'h0200_0000, 32'd1, 4'hF, 1'b0, 32'd0, "wr_msip_pre");
    xfer(32'h0200_4004, 32'd0, 4'hF, 1'b0, 32'd0, "wr_cmp_hi_pre");
    xfer(32'h0200_4000, 32'd0, 4'hF, 1'b0, 32'd0, "wr_cmp_lo_pre");
    chk("pre_reset_timer", 64'(timer_irpt), 64'd1);
    chk("pre_reset_soft", 64'(soft_irpt), 64'd1);
    mem_valid = 1'b1; mem_addr = 32'h0200_0000;
    @(negedge clk);
    chk("resp_before_reset", 64'(mem_ready), 64'd1);
    rst = 1'b0; mem_valid = 1'b0;
    base_val = 64'd0; base_edges = 0;
    @(negedge clk);
    chk("rst_resp_ready", 64'(mem_ready), 64'd0);
    chk("rst_resp_rdata", 64'(mem_rdata), 64'd0);
    chk("rst_resp_timer", 64'(timer_irpt), 64'd0);
    chk("rst_resp_soft", 64'(soft_irpt), 64'd0);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen = seen | mem_ready;
    end
    chk("no_ready_after_reset", 64'(seen), 64'd0);
    chk("timer_low_after_reset", 64'(timer_irpt), 64'd0);

    // Reset coinciding with a write: reset wins.
    rst = 1'b0; mem_valid = 1'b1; mem_addr = 32'h0200_0000;
    mem_wdata = 32'd1; mem_wstrb = 4'hF;
    @(negedge clk);
    rst = 1'b1; mem_valid = 1'b0; mem_wstrb = 4'h0;
    base_val = 64'd0; base_edges = 0;
    repeat (2) @(negedge clk);
    chk("rst_write_soft", 64'(soft_irpt), 64'd0);
    xfer(32'h0200_0000, 32'd0, 4'h0, 1'b1, 32'd0, "rst_write_msip");
    rd_mtime(1'b0, "rst_write_mtime");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
